ap_pp_gen_pipe: RTL and testbench

//   Upstream operand stage for the 8x8 unsigned approximate multiplier.
//   - Accepts operand pairs (a, b) over a valid/ready handshake.
//   - Forms the 64-bit AND partial-product vector in the row-major layout the

---
 rtl/ap_pp_gen_pipe_if.sv | 26 ++
 rtl/ap_pp_gen_pipe.sv | 89 ++++++++
 tb/tb_ap_pp_gen_pipe.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/ap_pp_gen_pipe_if.sv
// Operand/partial-product handshake bundle for the approximate-multiplier front end.
// The master side is the operand source and pp consumer; the slave side is ap_pp_gen_pipe.
interface ap_pp_gen_pipe_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic                     in_valid;
  logic                     in_ready;
  logic [WIDTH-1:0]         in_a;
  logic [WIDTH-1:0]         in_b;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH*WIDTH-1:0]   out_pp;
  logic                     out_zero;
  logic [CNT_W-1:0]         acc_cnt;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_pp, out_zero, acc_cnt
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_pp, out_zero, acc_cnt
  );
endinterface

// File: rtl/ap_pp_gen_pipe.sv
// Operand register plus small FIFO producing row-major AND partial-product vectors
// (pp[WIDTH*i+j] = a[j] & b[i]) for the ppcom compressor, with zero flag and accept counter.
module ap_pp_gen_pipe #(
  parameter int WIDTH      = 8,
  parameter int FIFO_DEPTH = 2,
  parameter int CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst,
  ap_pp_gen_pipe_if.slave    bus
);
  localparam int PP_W   = WIDTH * WIDTH;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int OCC_W  = $clog2(FIFO_DEPTH + 1);
  localparam logic [OCC_W-1:0] FULL_C = OCC_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] LAST_C = PTR_W'(FIFO_DEPTH - 1);

  function automatic logic [PP_W-1:0] form_pp(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    logic [PP_W-1:0] pp;
    pp = '0;
    for (int i = 0; i < WIDTH; i++)
      for (int j = 0; j < WIDTH; j++)
        pp[WIDTH*i+j] = a[j] & b[i];
    return pp;
  endfunction

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_C) ? '0 : p + PTR_W'(1);
  endfunction

  logic              vld_p1;
  logic [WIDTH-1:0]  a_p1;
  logic [WIDTH-1:0]  b_p1;
  logic              zero_p1;
  logic [PP_W:0]     mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [OCC_W-1:0]  fifo_cnt;
  logic [CNT_W-1:0]  acc_cnt_r;
  logic [PP_W:0]     head;
  logic              accept;
  logic              push;
  logic              pop;

  // A full FIFO refuses the push even when a pop coincides, keeping out_ready off the input path.
  assign push         = vld_p1 & (fifo_cnt != FULL_C);
  assign pop          = bus.out_valid & bus.out_ready;
  assign bus.in_ready = ~vld_p1 | push;
  assign accept       = bus.in_valid & bus.in_ready;
  assign zero_p1      = (a_p1 == '0) | (b_p1 == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1    <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifo_cnt  <= '0;
      acc_cnt_r <= '0;
    end else begin
      if (accept)    vld_p1 <= 1'b1;
      else if (push) vld_p1 <= 1'b0;
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + OCC_W'(1);
        2'b01:   fifo_cnt <= fifo_cnt - OCC_W'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (accept) acc_cnt_r <= acc_cnt_r + CNT_W'(1);
    end
  end

  // S1 operand capture and FIFO write; datapath storage carries no reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_p1 <= bus.in_a;
      b_p1 <= bus.in_b;
    end
    if (push) mem[wr_ptr] <= {form_pp(a_p1, b_p1), zero_p1};
  end

  // Head is gated by occupancy so unreset storage never shows at the outputs.
  assign head          = mem[rd_ptr];
  assign bus.out_valid = (fifo_cnt != '0);
  assign bus.out_pp    = bus.out_valid ? head[PP_W:1] : '0;
  assign bus.out_zero  = bus.out_valid ? head[0] : 1'b0;
  assign bus.acc_cnt   = acc_cnt_r;
endmodule

// File: tb/tb_ap_pp_gen_pipe.sv
// Scoreboard bench for ap_pp_gen_pipe: accepted pairs queue their expected vector,
// an independent monitor compares every presented head against the queue front.
module tb_ap_pp_gen_pipe;
  typedef struct packed {
    logic [63:0] pp;
    logic        z;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  bit   rnd_mode = 1'b0;
  bit   ready_force = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  ap_pp_gen_pipe_if #(.WIDTH(8), .CNT_W(16)) bus ();

  ap_pp_gen_pipe #(.WIDTH(8), .FIFO_DEPTH(2), .CNT_W(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Long-multiplication view: each set bit of b contributes a copy of a shifted by its row.
  function automatic exp_t ref_model(input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    e.pp = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) e.pp = e.pp | (64'(a) << (8 * i));
    e.z = ((16'(a) * 16'(b)) == 16'd0);
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h at %0t", nm, act, req, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (rnd_mode) bus.out_ready = ($urandom_range(0, 7) != 0);
    else          bus.out_ready = ready_force;
  end

  always @(negedge clk) begin
    if (!rst && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got %h required no output at %0t", bus.out_pp, $time);
      end else begin
        chk("out_pp", bus.out_pp, exp_q[0].pp);
        chk("out_zero", 64'(bus.out_zero), 64'(exp_q[0].z));
        if (bus.out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b);
    bit done = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    for (int t = 0; t < 2000 && !done; t++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        exp_q.push_back(ref_model(a, b));
        done = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    bus.in_a     = 'x;
    bus.in_b     = 'x;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: got in_ready=0 required accept within 2000 cycles");
    end
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int t = 0; t < 5000 && !done; t++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && !bus.out_valid) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d pending required 0", exp_q.size());
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got no finish required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] av[4];
    logic [7:0] bv[4];
    logic [7:0] ra, rb;
    bus.in_valid = 1'b0;
    bus.in_a     = '0;
    bus.in_b     = '0;
    ready_force  = 1'b1;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_pp", bus.out_pp, 64'd0);
    chk("rst_out_zero", 64'(bus.out_zero), 64'd0);
    chk("rst_acc_cnt", 64'(bus.acc_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Test 1: all-ones operands and two-edge latency
    send(8'hFF, 8'hFF);
    chk("lat_not_yet", 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    #1;
    chk("lat_valid", 64'(bus.out_valid), 64'd1);
    chk("ff_pp", bus.out_pp, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("ff_zero", 64'(bus.out_zero), 64'd0);
    chk("ff_acc_cnt", 64'(bus.acc_cnt), 64'd1);

    // Test 2: single corner bit, then zero operand
    send(8'h01, 8'h80);
    @(posedge clk);
    #1;
    chk("bit56_pp", bus.out_pp, 64'h0100_0000_0000_0000);
    chk("bit56_zero", 64'(bus.out_zero), 64'd0);
    send(8'h00, 8'h5A);
    @(posedge clk);
    #1;
    chk("zero_pp", bus.out_pp, 64'd0);
    chk("zero_flag", 64'(bus.out_zero), 64'd1);
    drain();

    // Test 3: backpressure fills FIFO and S1, then releases in order
    do_reset();
    ready_force = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      av[i] = 8'($urandom);
      bv[i] = 8'($urandom);
    end
    for (int i = 0; i < 3; i++) send(av[i], bv[i]);
    bus.in_valid = 1'b1;
    bus.in_a     = av[3];
    bus.in_b     = bv[3];
    repeat (2) @(posedge clk);
    #1;
    chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
    chk("bp_acc_cnt", 64'(bus.acc_cnt), 64'd3);
    chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
    ready_force = 1'b1;
    send(av[3], bv[3]);
    drain();

    // Test 5: asynchronous reset with FIFO full and S1 occupied
    ready_force = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) send(8'($urandom), 8'($urandom));
    @(posedge clk);
    #1;
    chk("pre_rst_in_ready", 64'(bus.in_ready), 64'd0);
    #2 rst = 1'b1;
    exp_q.delete();
    #1;
    chk("mid_rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("mid_rst_acc_cnt", 64'(bus.acc_cnt), 64'd0);
    chk("mid_rst_out_pp", bus.out_pp, 64'd0);
    ready_force = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_no_stale", 64'(bus.out_valid), 64'd0);

    // Test 4: randomized traffic with random backpressure
    rnd_mode = 1'b1;
    for (int n = 0; n < 10000; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk);
        #1;
      end
      ra = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom);
      rb = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom);
      send(ra, rb);
    end
    rnd_mode = 1'b0;
    ready_force = 1'b1;
    drain();
    chk("rand_acc_cnt", 64'(bus.acc_cnt), 64'd10000);

    // Test 6: accept counter wrap
    do_reset();
    for (int n = 0; n < 65535; n++) send(8'(n), 8'(n >> 8));
    chk("cnt_all_ones", 64'(bus.acc_cnt), 64'hFFFF);
    send(8'hA5, 8'h3C);
    chk("cnt_wrap", 64'(bus.acc_cnt), 64'd0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
